// File: rtl/adder_8_pkg.sv
// Shared constants for the adder_8 registered ripple-carry adder.
package adder_8_pkg;

    localparam int unsigned ADDER_8_WIDTH = 8;

    localparam logic [ADDER_8_WIDTH-1:0] ADDER_8_SUM_RST  = 8'h00;
    localparam logic                     ADDER_8_COUT_RST = 1'b0;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; one stage of the adder_8 ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_8.sv
// Registered 8-bit unsigned ripple-carry adder with carry-out.
// Define ADDER_8_FLAGS_EN to add registered zero and signed-overflow flags.
module adder_8
    import adder_8_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [ADDER_8_WIDTH-1:0] i_A,
    input  logic [ADDER_8_WIDTH-1:0] i_B,
    output logic [ADDER_8_WIDTH-1:0] o_S,
`ifdef ADDER_8_FLAGS_EN
    output logic                     o_Cout,
    output logic                     o_Zero,
    output logic                     o_Ovf
`else
    output logic                     o_Cout
`endif
);

    logic [ADDER_8_WIDTH:0]   carry_c;
    logic [ADDER_8_WIDTH-1:0] sum_c;

    assign carry_c[0] = 1'b0;

    // Ripple chain: carry of stage k feeds stage k+1, last carry is Cout.
    for (genvar k = 0; k < ADDER_8_WIDTH; k++) begin : g_fa
        full_adder u_fa (
            .a    (i_A[k]),
            .b    (i_B[k]),
            .cin  (carry_c[k]),
            .s    (sum_c[k]),
            .cout (carry_c[k+1])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_S    <= ADDER_8_SUM_RST;
            o_Cout <= ADDER_8_COUT_RST;
        end else begin
            o_S    <= sum_c;
            o_Cout <= carry_c[ADDER_8_WIDTH];
        end
    end

`ifdef ADDER_8_FLAGS_EN
    logic zero_c;
    logic ovf_c;

    // Overflow: like-signed operands producing a result of the other sign.
    assign zero_c = (sum_c == '0);
    assign ovf_c  = (i_A[ADDER_8_WIDTH-1] == i_B[ADDER_8_WIDTH-1]) &&
                    (sum_c[ADDER_8_WIDTH-1] != i_A[ADDER_8_WIDTH-1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_Zero <= 1'b0;
            o_Ovf  <= 1'b0;
        end else begin
            o_Zero <= zero_c;
            o_Ovf  <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_adder_8.sv
// Self-checking bench for adder_8: directed vectors plus a full operand sweep.
// Build with ADDER_8_FLAGS_EN defined to also check o_Zero and o_Ovf.
module tb_adder_8;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_A;
    logic [7:0] i_B;
    logic [7:0] o_S;
    logic       o_Cout;
`ifdef ADDER_8_FLAGS_EN
    logic       o_Zero;
    logic       o_Ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp;
        logic       zero;
        logic       ovf;
    } vec_t;

    adder_8 u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_A     (i_A),
        .i_B     (i_B),
        .o_S     (o_S),
`ifdef ADDER_8_FLAGS_EN
        .o_Cout  (o_Cout),
        .o_Zero  (o_Zero),
        .o_Ovf   (o_Ovf)
`else
        .o_Cout  (o_Cout)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare {Cout,S} and, when built in, the two flags.
    task automatic check_out(input string tag, input logic [8:0] exp9,
                             input logic ez, input logic eo);
        chk(tag, {o_Cout, o_S}, exp9);
`ifdef ADDER_8_FLAGS_EN
        chk({tag, "_zero"}, 9'(o_Zero), 9'(ez));
        chk({tag, "_ovf"},  9'(o_Ovf),  9'(eo));
`else
        if (ez === 1'bz && eo === 1'bz) $display("note: unused flag expectations");
`endif
    endtask

    // Drive operands, let one rising edge capture them, sample just after.
    task automatic step(input logic [7:0] a, input logic [7:0] b);
        i_A = a;
        i_B = b;
        @(posedge i_clk);
        #1;
    endtask

    vec_t b2b [6];

    initial begin
        b2b[0] = '{8'h01, 8'h02, 9'h003, 1'b0, 1'b0};
        b2b[1] = '{8'h10, 8'h20, 9'h030, 1'b0, 1'b0};
        b2b[2] = '{8'hF0, 8'h20, 9'h110, 1'b0, 1'b0};
        b2b[3] = '{8'hAA, 8'h55, 9'h0FF, 1'b0, 1'b0};
        b2b[4] = '{8'hFF, 8'hFF, 9'h1FE, 1'b0, 1'b0};
        b2b[5] = '{8'h40, 8'h40, 9'h080, 1'b0, 1'b1};

        i_rst_n = 1'b1;
        i_A     = 8'h55;
        i_B     = 8'hAA;

        // Asynchronous assert before any clock edge.
        #1 i_rst_n = 1'b0;
        #1 check_out("rst_async", 9'h000, 1'b0, 1'b0);

        // Clock edges while held in reset do nothing.
        repeat (3) @(posedge i_clk);
        #1 check_out("rst_hold", 9'h000, 1'b0, 1'b0);

        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(8'h07, 8'hFB); check_out("first_cap", 9'h102, 1'b0, 1'b0);
        step(8'hFF, 8'h01); check_out("wrap_ff01", 9'h100, 1'b1, 1'b0);
        step(8'h7F, 8'h01); check_out("ovf_7f01",  9'h080, 1'b0, 1'b1);
        step(8'h80, 8'h80); check_out("ovf_8080",  9'h100, 1'b1, 1'b1);
        step(8'h00, 8'h00); check_out("zero_0000", 9'h000, 1'b1, 1'b0);

        // Operand change between edges must not reach the outputs.
        #2;
        i_A = 8'h12;
        i_B = 8'h34;
        #2 check_out("mid_hold", 9'h000, 1'b1, 1'b0);
        @(posedge i_clk);
        #1 check_out("mid_next", 9'h046, 1'b0, 1'b0);

        foreach (b2b[i]) begin
            step(b2b[i].a, b2b[i].b);
            check_out($sformatf("b2b_%0d", i), b2b[i].exp, b2b[i].zero, b2b[i].ovf);
        end

        // Reset pulse in the middle of a stream.
        step(8'hC3, 8'h3C); check_out("pre_rst", 9'h0FF, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1 check_out("mid_rst_async", 9'h000, 1'b0, 1'b0);
        @(posedge i_clk);
        #1 check_out("mid_rst_hold", 9'h000, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1 check_out("resume", 9'h0FF, 1'b0, 1'b0);

        // Full sweep of every operand pair, one pair per cycle.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                step(8'(a), 8'(b));
                chk("sweep", {o_Cout, o_S}, 9'(a) + 9'(b));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_8.md
# adder_8

Registered 8-bit unsigned binary adder producing an 8-bit sum and a carry-out. Built as a ripple-carry chain of single-bit full adders, with both results captured in output registers on the single system clock. Serves as a leaf arithmetic block for datapath and teaching designs. Upstream logic drives the operands continuously, and downstream logic samples the registered results.

## Interface
Parameters:
- none. Width is fixed at 8 bits and comes from the shared package constant.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_A  input  8  operand A, unsigned.
- i_B  input  8  operand B, unsigned.
- o_S  output  8  registered sum, i_A + i_B modulo 256.
- o_Cout  output  1  registered carry-out, bit 8 of i_A + i_B.
- o_Zero  output  1  registered flag, high when the sum is 0x00. Present only with ADDER_8_FLAGS_EN.
- o_Ovf  output  1  registered signed-overflow flag. Present only with ADDER_8_FLAGS_EN.

## Operation
- The combinational core computes the 9-bit result {Cout, S} = i_A + i_B as a ripple chain.
  - Bit 0 carry-in is tied to 0.
  - Carry of bit k feeds carry-in of bit k+1.
  - Carry of bit 7 is Cout.
- There is no carry-in port and no valid handshake. Inputs are sampled every clock edge.
- Arithmetic is unsigned. The sum wraps modulo 256 and the wrapped-out bit appears on o_Cout.
- With ADDER_8_FLAGS_EN:
  - o_Zero = (S == 0), evaluated on the 8-bit sum only; Cout is ignored.
  - o_Ovf = (A[7] == B[7]) && (S[7] != A[7]).
- X or Z on the inputs is not filtered. The outputs follow the inputs.

## Timing
- Latency is 1 cycle. Operands present at rising edge N appear on o_S, o_Cout and the flags after edge N, stable until edge N+1.
- Throughput is one addition per cycle. The ripple chain must close timing within one clock period.
- Reset values: o_S = 0x00, o_Cout = 0, o_Zero = 0, o_Ovf = 0.
- Asserting i_rst_n low forces all outputs to their reset values immediately, without waiting for a clock edge, including mid-stream.
- While i_rst_n is low, clock edges have no effect.
- The first capture happens on the first rising edge after i_rst_n goes high.
- Operand changes between edges do not affect the outputs until the next edge.

## Configuration
- ADDER_8_FLAGS_EN defined: o_Zero and o_Ovf ports and their registers exist, with behaviour as above.
- Not defined: those ports and registers are absent. o_S and o_Cout behaviour is identical in both builds.

## Structure
- Shared package adder_8_pkg:
  - ADDER_8_WIDTH = 8.
  - Reset-value constants for the sum (8'h00) and the carry (1'b0).
- One sub-module, full_adder: inputs a, b, cin; outputs s, cout, where s = a^b^cin and cout = majority(a, b, cin).
- adder_8 instantiates full_adder 8 times in a generate loop, plus the output register block and the optional flag logic.

## Test plan
- Reset held low, inputs arbitrary -> o_S = 0x00, o_Cout = 0 (flags 0) with no clock edge required. Deassert, then drive A = 0x07, B = 0xFB -> after next edge o_S = 0x02, o_Cout = 1.
- A = 0xFF, B = 0x01 -> o_S = 0x00, o_Cout = 1; with flags o_Zero = 1, o_Ovf = 0.
- A = 0x7F, B = 0x01 -> o_S = 0x80, o_Cout = 0; with flags o_Ovf = 1. Then A = 0x80, B = 0x80 -> o_S = 0x00, o_Cout = 1, o_Ovf = 1.
- A = 0x00, B = 0x00 -> o_S = 0x00, o_Cout = 0; change operands mid-cycle -> outputs unchanged until the next rising edge.
- Back-to-back operand changes every cycle -> each result appears exactly one edge later. Assert i_rst_n mid-stream -> outputs clear asynchronously, and results resume on the first edge after release.
- Exhaustive sweep of all 65536 (A, B) pairs -> {o_Cout, o_S} equals A + B one cycle after each pair.
